bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence-detector stage.
- Accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on a registered serial line, which drives the detector's single-bit `in`.
- A one-word holding register lets back-to-back words stream with no idle gap, so patterns spanning word boundaries stay contiguous.
- Idle cycles drive a fixed IDLE_BIT level.

Parameters:
- DATA_W, 8: word width in bits (>=2).
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b0: level driven on ser_out when no word is shifting.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  DATA_W  word to serialize.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit, registered; connects to the detector's in.
- ser_valid  output  1  ser_out carries a data bit (not idle fill).
- frame_done  output  1  one-cycle pulse concurrent with the last bit of each word.
- busy  output  1  shifting, or holding register occupied.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; shift register, hold register and bit counter cleared; hold_full=0.
  - ser_out=IDLE_BIT, ser_valid=0, frame_done=0, busy=0, load_ready=1.
  - Reset mid-frame discards the in-flight and held words; no partial word resumes after release.
- Handshake:
  - Accept occurs on an edge where load_valid && load_ready.
  - load_ready = ~hold_full (combinational from registered state).
  - data_in is sampled only on accept and is ignored otherwise.
- States: IDLE, SHIFT (2-bit encoding from the package).
- IDLE:
  - On accept, data_in loads the shift register; bit_cnt=DATA_W-1; go to SHIFT.
  - The first bit appears on ser_out with ser_valid=1 in the cycle after the accepting edge (latency 1).
  - Hold register is bypassed in this case.
- SHIFT:
  - Each edge presents the next bit (MSB_FIRST order) and decrements bit_cnt.
  - ser_valid=1 throughout.
  - frame_done=1 while the last bit (bit_cnt==0) is on ser_out.
  - Accept during SHIFT writes data_in into the hold register; hold_full=1.
- End of word (edge leaving the last bit):
  - If hold_full: hold moves to the shift register, hold_full=0, stay in SHIFT. The first bit of the next word follows the last bit with zero gap.
  - Else if accept on the same edge: data_in goes straight into the shift register (bypass), stay in SHIFT, zero gap.
  - Else: go to IDLE; next cycle ser_out=IDLE_BIT, ser_valid=0.
- Simultaneous hold_full and load_valid: load_ready=0, so no accept happens. The upstream producer holds data_in.
- Throughput:
  - Sustained one word per DATA_W cycles.
  - At most one accepted word plus one shifting word in flight.
- Bit counter width is $clog2(DATA_W). It never wraps below 0; reload happens at end of word.
- busy = (state==SHIFT) | hold_full.

Decomposition:
- Shared package `serial_pkg`:
  - state encodings IDLE/SHIFT;
  - IDLE_BIT default;
  - the detector's state constants S0..S4, so both stages and benches share one definition.
- One natural sub-module: `ser_hold_reg` (one-entry DATA_W register with full flag, write/read strobes, async active-low clear).
- The shift/counter FSM stays in bit_serializer.

Test Plan:
- Reset, then idle for 10 cycles -> ser_out=0, ser_valid=0, load_ready=1, busy=0 throughout.
- Load 8'b10011000 with MSB_FIRST=1 -> on the 8 cycles after accept, ser_out=1,0,0,1,1,0,0,0; frame_done high only on cycle 8. A downstream detector fed from ser_out pulses out once, on the fifth bit.
- Back-to-back: present 8'hA5 then 8'h3C with load_valid held high ->
  - second word accepted into hold on the edge after the first accept;
  - load_ready=0 until hold drains;
  - 16 contiguous ser_valid cycles, bits 10100101 00111100, no gap.
- Bypass: accept 8'hFF exactly on the edge leaving the last bit of a prior word with hold empty -> zero-gap transition; hold_full never set.
- Reset asserted on the 4th bit of 8'hC3 -> ser_out=IDLE_BIT and ser_valid=0 immediately (asynchronous), busy=0. After release, no remaining bits of 8'hC3 appear.
- MSB_FIRST=0, DATA_W=4, load 4'b0011 -> ser_out=1,1,0,0; frame_done on the 4th bit.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serializer front end and the sequence detector stage.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } ser_state_e;

  localparam logic IDLE_BIT_DEF = 1'b0;

  // Detector state constants, kept here so both stages and their benches agree.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  localparam int DET_NUM_STATES = 5;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register with full flag; lets a second word wait while the first shifts.
module ser_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // Capture on write, release on read; writes only arrive while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {DATA_W{1'b0}};
      r_full <= 1'b0;
    end else begin
      if (i_wr) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end else begin
        r_full <= r_full;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: words in over valid/ready, one registered bit per clock out,
// with a one-word hold register so consecutive words stream without a gap.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  ser_state_e        r_state;
  ser_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_frame_done;
  logic              w_ser_out_nxt;
  logic              w_ser_valid_nxt;
  logic              w_frame_done_nxt;
  logic              w_accept;
  logic              w_hold_full;
  logic              w_hold_wr;
  logic              w_hold_rd;
  logic [DATA_W-1:0] w_hold_data;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_W-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  ser_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk    (clk),
    .rst_n  (reset),
    .i_wr   (w_hold_wr),
    .i_rd   (w_hold_rd),
    .i_data (data_in),
    .o_data (w_hold_data),
    .o_full (w_hold_full)
  );

  assign load_ready = ~w_hold_full;
  assign w_accept   = load_valid & ~w_hold_full;
  assign busy       = (r_state == SHIFT) | w_hold_full;

  // Next-state logic for the shift/count FSM and the hold-register strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_hold_wr   = 1'b0;
    w_hold_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_nxt = data_in;
          w_cnt_nxt   = CNT_LAST;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_ZERO) begin
          // Last bit leaving: a held word wins; otherwise a same-edge accept bypasses the hold.
          if (w_hold_full) begin
            w_shift_nxt = w_hold_data;
            w_cnt_nxt   = CNT_LAST;
            w_hold_rd   = 1'b1;
          end else if (w_accept) begin
            w_shift_nxt = data_in;
            w_cnt_nxt   = CNT_LAST;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_shift_nxt = advance(r_shift);
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          if (w_accept) begin
            w_hold_wr = 1'b1;
          end else begin
            w_hold_wr = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_ser_valid_nxt  = (w_state_nxt == SHIFT);
  assign w_ser_out_nxt    = w_ser_valid_nxt ? first_bit(w_shift_nxt) : IDLE_BIT;
  assign w_frame_done_nxt = w_ser_valid_nxt & (w_cnt_nxt == CNT_ZERO);

  // State, datapath and registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_shift      <= {DATA_W{1'b0}};
      r_cnt        <= CNT_ZERO;
      r_ser_out    <= IDLE_BIT;
      r_ser_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ser_out    <= w_ser_out_nxt;
      r_ser_valid  <= w_ser_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an 8-bit MSB-first instance and a 4-bit LSB-first instance.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready, ser_out, ser_valid, frame_done, busy;
  logic [3:0] data4;
  logic       lv4;
  logic       lr4, so4, sv4, fd4, busy4;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp4_q[$];

  always #5 clk = ~clk;

  bit_serializer u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  bit_serializer #(.DATA_W(4), .MSB_FIRST(0)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data4),
    .load_valid (lv4),
    .load_ready (lr4),
    .ser_out    (so4),
    .ser_valid  (sv4),
    .frame_done (fd4),
    .busy       (busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: every valid bit must match the head of the queue.
  always @(negedge clk) begin : mon8
    logic [1:0] e;
    if (ser_valid === 1'b1) begin
      run_len++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit8: got ser_out=%0b with no word pending (t=%0t)", ser_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("bit8", {31'd0, ser_out}, {31'd0, e[1]});
        chk("frame_done8", {31'd0, frame_done}, {31'd0, e[0]});
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      chk("frame_done_idle8", {31'd0, frame_done}, 32'd0);
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin : mon4
    logic [1:0] e;
    if (sv4 === 1'b1) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit4: got ser_out=%0b with no word pending (t=%0t)", so4, $time);
      end else begin
        e = exp4_q.pop_front();
        chk("bit4", {31'd0, so4}, {31'd0, e[1]});
        chk("frame_done4", {31'd0, fd4}, {31'd0, e[0]});
      end
    end else begin
      chk("idle_level4", {31'd0, so4}, 32'd0);
    end
  end

  // Present a word and hold it until accepted; queue its expected MSB-first bits.
  task automatic offer(input logic [7:0] w);
    int n;
    data_in    = w;
    load_valid = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL accept_timeout: load_ready stayed %0b, expected 1 for word %02h", load_ready, w);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({w[7-i], (i == 7) ? 1'b1 : 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer4(input logic [3:0] w);
    data4 = w;
    lv4   = 1'b1;
    chk("ready4", {31'd0, lr4}, 32'd1);
    for (int i = 0; i < 4; i++) exp4_q.push_back({w[i], (i == 3) ? 1'b1 : 1'b0});
    @(posedge clk);
    #1;
    lv4 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    chk("drain_pending", exp_q.size() + exp4_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset      = 1'b0;
    data_in    = 8'h00;
    load_valid = 1'b0;
    data4      = 4'h0;
    lv4        = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_ser_out", {31'd0, ser_out}, 32'd0);
      chk("idle_ser_valid", {31'd0, ser_valid}, 32'd0);
      chk("idle_load_ready", {31'd0, load_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_load_ready4", {31'd0, lr4}, 32'd1);
    end

    // Single word 10011000
    offer(8'b1001_1000);
    load_valid = 1'b0;
    chk("busy_single", {31'd0, busy}, 32'd1);
    wait_drain();
    chk("run_single", last_run, 32'd8);
    chk("busy_after_single", {31'd0, busy}, 32'd0);

    // Back-to-back A5 then 3C with load_valid held high
    offer(8'hA5);
    offer(8'h3C);
    load_valid = 1'b0;
    cnt = 0;
    @(negedge clk);
    #1;
    chk("busy_held", {31'd0, busy}, 32'd1);
    while (load_ready !== 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("hold_drain_cycles", cnt, 32'd7);
    wait_drain();
    chk("run_back_to_back", last_run, 32'd16);

    // Bypass: FF accepted on the edge leaving the last bit of 11
    offer(8'h11);
    load_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("fd_before_bypass", {31'd0, frame_done}, 32'd1);
    chk("bypass_ready", {31'd0, load_ready}, 32'd1);
    offer(8'hFF);
    load_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("no_hold_after_bypass", {31'd0, load_ready}, 32'd1);
    chk("valid_after_bypass", {31'd0, ser_valid}, 32'd1);
    wait_drain();
    chk("run_bypass", last_run, 32'd16);

    // Reset on the 4th bit of C3
    offer(8'hC3);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", {31'd0, ser_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // 4-bit LSB-first instance
    offer4(4'b0011);
    wait_drain();
    offer4(4'b1000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
